print_queue_ctrl: RTL and testbench
===================================

# print_queue_ctrl

Parametrised successor of the single-job printer controller. It buffers print jobs in a page-count FIFO and runs warm-up, load and print phases with configurable durations. It stays warm between back-to-back jobs, drops to sleep after an idle timeout, and handles paper jams. It sits between the job-submission front end and the printer mechanism drivers.

## Interface
- PAGE_W, 8: width of page count per job
- QDEPTH, 4: job FIFO depth, power of two, ≥2
- WARM_CYCLES, 100: cycles in WARMING, ≥1
- LOAD_CYCLES, 1: cycles per LOADING phase, ≥1
- PRINT_CYCLES, 1: cycles per PRINTING phase, ≥1
- IDLE_CYCLES, 16: empty cycles in READY before SLEEPING, ≥1
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1)
- push  in  1  job submit strobe; accepted when push && push_ready
- pages  in  PAGE_W  page count of submitted job
- push_ready  out  1  FIFO not full
- jam  in  1  paper-jam level from mechanism
- jam_clr  in  1  operator clear strobe
- warm  out  1  heater on (WARMING)
- loadpage  out  1  LOADING
- printpage  out  1  PRINTING
- fault  out  1  JAMMED
- busy  out  1  state ≠ SLEEPING or FIFO non-empty
- pages_left  out  PAGE_W  pages remaining in current job
- jobs_pending  out  $clog2(QDEPTH)+1  FIFO occupancy

## Operation
- States: SLEEPING, WARMING, READY, LOADING, PRINTING, JAMMED.
- SLEEPING: FIFO non-empty → WARMING. Timer cleared.
- WARMING: stays for WARM_CYCLES cycles → READY.
- READY, pages_left ≠ 0 → LOADING.
- READY, pages_left = 0, FIFO non-empty: pop head into pages_left, idle timer cleared.
  - Head ≠ 0 → LOADING next cycle.
  - Head = 0: job discarded, stay READY.
- READY, pages_left = 0, FIFO empty: idle timer counts. Reaching IDLE_CYCLES → SLEEPING.
- LOADING: LOAD_CYCLES cycles → PRINTING.
- PRINTING: PRINT_CYCLES cycles. On its last cycle, pages_left decrements. Then → LOADING if pages_left was > 1, else → READY.
- jam = 1 in LOADING or PRINTING → JAMMED next cycle. The page in flight is not decremented; pages_left is retained.
- JAMMED: leaves only when jam_clr = 1 and jam = 0 in the same cycle → WARMING (full re-warm), then resumes with the retained pages_left.
- jam is ignored in other states.
- FIFO push: accepted when push && push_ready.
  - Push when full: dropped silently, no state change.
  - Simultaneous push and pop: both take effect, occupancy unchanged.
  - A pages = 0 job is accepted and discarded at pop.
- Outputs are decoded from the state register only (Moore). Exactly one of warm/loadpage/printpage/fault is high, or none in SLEEPING/READY.
- Reset (async, any state, mid-job): state SLEEPING, FIFO emptied, timer 0, pages_left 0. All outputs 0 except push_ready = 1.

## Timing
- One timer, width $clog2 of the largest duration parameter. It is cleared on every state change.
- Each phase lasts exactly its parameter count in cycles.
- Push in cycle t with SLEEPING and an empty FIFO:
  - occupancy = 1 at t+1
  - warm high t+2 … t+1+WARM_CYCLES
  - READY (pop) at t+2+WARM_CYCLES
  - loadpage first at t+3+WARM_CYCLES
- Job arriving in READY with an empty FIFO: push t, pop t+1, loadpage t+2. No re-warm.
- pages_left and jobs_pending update on the clock edge following the event.

## Structure
- Package print_pkg:
  - state enum (3-bit)
  - state-to-output decode function
  - default parameter constants
- Sub-module print_job_fifo (PAGE_W × QDEPTH). Ports: push, pop, din, dout (head, show-ahead), full, empty, count. Same clk and async active-high rst_n.
- Controller FSM, timer and pages_left register live in print_queue_ctrl.

## Test plan
- WARM_CYCLES=4, LOAD=PRINT=1, IDLE=16; push pages=3 at cycle 0 → warm cycles 2–5, READY 6, loadpage 7/9/11, printpage 8/10/12, pages_left 3→2→1→0 after 8/10/12, READY 13, SLEEPING 29.
- Push jobs 2 and 1 on consecutive cycles from SLEEPING → a single warm-up, 3 load/print pairs, one READY pop cycle between jobs, jobs_pending 2→1→0.
- Push 5 jobs back-to-back into depth 4 while WARMING → push_ready low after the fourth, fifth job dropped, exactly 4 jobs printed.
- Assert jam during the second PRINTING of a 3-page job → JAMMED, fault = 1, pages_left = 2. jam_clr with jam still high → no exit. jam_clr with jam = 0 → full warm-up, then 2 pages printed.
- Push pages=0 followed by pages=1 → the zero job is discarded with no loadpage; exactly one load/print follows.
- Assert rst_n mid-PRINTING with 2 jobs queued → immediately SLEEPING, outputs 0, jobs_pending 0, push_ready 1. No activity after release until a new push.

Source files
------------

// File: rtl/print_pkg.sv
// Shared types, defaults and helpers for the queued printer controller.
package print_pkg;

  localparam int DEF_PAGE_W       = 8;
  localparam int DEF_QDEPTH       = 4;
  localparam int DEF_WARM_CYCLES  = 100;
  localparam int DEF_LOAD_CYCLES  = 1;
  localparam int DEF_PRINT_CYCLES = 1;
  localparam int DEF_IDLE_CYCLES  = 16;

  typedef enum logic [2:0] {
    ST_SLEEPING = 3'd0,
    ST_WARMING  = 3'd1,
    ST_READY    = 3'd2,
    ST_LOADING  = 3'd3,
    ST_PRINTING = 3'd4,
    ST_JAMMED   = 3'd5
  } state_e;

  typedef struct packed {
    logic warm;
    logic loadpage;
    logic printpage;
    logic fault;
  } mech_out_t;

  // Moore decode: at most one mechanism output per state
  function automatic mech_out_t decode_state(input state_e st);
    mech_out_t o;
    o = '0;
    case (st)
      ST_WARMING:  o.warm      = 1'b1;
      ST_LOADING:  o.loadpage  = 1'b1;
      ST_PRINTING: o.printpage = 1'b1;
      ST_JAMMED:   o.fault     = 1'b1;
      default:     o           = '0;
    endcase
    return o;
  endfunction

  function automatic int max_dur(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/print_job_fifo.sv
// Show-ahead FIFO of per-job page counts; writes to a full FIFO are dropped.
module print_job_fifo
  import print_pkg::*;
#(
  parameter int PAGE_W = DEF_PAGE_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PAGE_W-1:0]          din,
  output logic [PAGE_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(QDEPTH):0]    count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [PAGE_W-1:0] mem_r [QDEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              wr_en_s;
  logic              rd_en_s;

  assign full    = (count_r == CW'(QDEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign dout    = mem_r[rd_ptr_r];
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_r[i] <= {PAGE_W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/print_queue_ctrl.sv
// Queued printer controller: job FIFO, phase FSM with shared timer, jam recovery.
module print_queue_ctrl
  import print_pkg::*;
#(
  parameter int PAGE_W       = DEF_PAGE_W,
  parameter int QDEPTH       = DEF_QDEPTH,
  parameter int WARM_CYCLES  = DEF_WARM_CYCLES,
  parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int PRINT_CYCLES = DEF_PRINT_CYCLES,
  parameter int IDLE_CYCLES  = DEF_IDLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [PAGE_W-1:0]        pages,
  output logic                     push_ready,
  input  logic                     jam,
  input  logic                     jam_clr,
  output logic                     warm,
  output logic                     loadpage,
  output logic                     printpage,
  output logic                     fault,
  output logic                     busy,
  output logic [PAGE_W-1:0]        pages_left,
  output logic [$clog2(QDEPTH):0]  jobs_pending
);

  localparam int MAXD = max_dur(WARM_CYCLES, LOAD_CYCLES, PRINT_CYCLES, IDLE_CYCLES);
  localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  state_e            state_r, state_nxt_s;
  logic [TW-1:0]     timer_r, timer_nxt_s;
  logic [PAGE_W-1:0] pages_left_r, pages_nxt_s;
  logic              pop_s;
  logic              timer_clr_s;
  logic [PAGE_W-1:0] head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  mech_out_t         mech_s;

  print_job_fifo #(
    .PAGE_W (PAGE_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_s),
    .din   (pages),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (jobs_pending)
  );

  // Next-state, pop and pages_left update; jam in LOADING/PRINTING beats phase completion
  always_comb begin
    state_nxt_s = state_r;
    pages_nxt_s = pages_left_r;
    pop_s       = 1'b0;
    timer_clr_s = 1'b0;
    case (state_r)
      ST_SLEEPING: begin
        if (!fifo_empty_s) state_nxt_s = ST_WARMING;
        else               state_nxt_s = ST_SLEEPING;
      end
      ST_WARMING: begin
        if (timer_r == TW'(WARM_CYCLES - 1)) state_nxt_s = ST_READY;
        else                                 state_nxt_s = ST_WARMING;
      end
      ST_READY: begin
        if (pages_left_r != {PAGE_W{1'b0}}) begin
          state_nxt_s = ST_LOADING;
        end else if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          timer_clr_s = 1'b1;
          pages_nxt_s = head_s;
          if (head_s != {PAGE_W{1'b0}}) state_nxt_s = ST_LOADING;
          else                          state_nxt_s = ST_READY;
        end else if (timer_r == TW'(IDLE_CYCLES - 1)) begin
          state_nxt_s = ST_SLEEPING;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      ST_LOADING: begin
        if (jam)                                   state_nxt_s = ST_JAMMED;
        else if (timer_r == TW'(LOAD_CYCLES - 1))  state_nxt_s = ST_PRINTING;
        else                                       state_nxt_s = ST_LOADING;
      end
      ST_PRINTING: begin
        if (jam) begin
          state_nxt_s = ST_JAMMED;
        end else if (timer_r == TW'(PRINT_CYCLES - 1)) begin
          if (pages_left_r != {PAGE_W{1'b0}}) pages_nxt_s = pages_left_r - 1'b1;
          else                                pages_nxt_s = pages_left_r;
          if (pages_left_r > PAGE_W'(1)) state_nxt_s = ST_LOADING;
          else                           state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_PRINTING;
        end
      end
      ST_JAMMED: begin
        if (jam_clr && !jam) state_nxt_s = ST_WARMING;
        else                 state_nxt_s = ST_JAMMED;
      end
      default: begin
        state_nxt_s = ST_SLEEPING;
        pages_nxt_s = {PAGE_W{1'b0}};
      end
    endcase
  end

  // Timer restarts on every state change and on each pop; parked at zero while sleeping or jammed
  always_comb begin
    timer_nxt_s = timer_r + 1'b1;
    if (state_nxt_s != state_r || timer_clr_s ||
        state_r == ST_SLEEPING || state_r == ST_JAMMED) begin
      timer_nxt_s = {TW{1'b0}};
    end else begin
      timer_nxt_s = timer_r + 1'b1;
    end
  end

  // State, timer and remaining-page registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r      <= ST_SLEEPING;
      timer_r      <= {TW{1'b0}};
      pages_left_r <= {PAGE_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      pages_left_r <= pages_nxt_s;
    end
  end

  assign mech_s     = decode_state(state_r);
  assign warm       = mech_s.warm;
  assign loadpage   = mech_s.loadpage;
  assign printpage  = mech_s.printpage;
  assign fault      = mech_s.fault;
  assign busy       = (state_r != ST_SLEEPING) || !fifo_empty_s;
  assign push_ready = !fifo_full_s;
  assign pages_left = pages_left_r;

endmodule

// File: tb/tb_print_queue_ctrl.sv
// Directed bench for print_queue_ctrl with short warm-up (4) and idle (16) timing.
module tb_print_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, push, jam, jam_clr;
  logic [7:0] pages;
  logic       push_ready, warm, loadpage, printpage, fault, busy;
  logic [7:0] pages_left;
  logic [2:0] jobs_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  print_queue_ctrl #(
    .PAGE_W(8), .QDEPTH(4), .WARM_CYCLES(4), .LOAD_CYCLES(1),
    .PRINT_CYCLES(1), .IDLE_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pages(pages), .push_ready(push_ready),
    .jam(jam), .jam_clr(jam_clr), .warm(warm), .loadpage(loadpage),
    .printpage(printpage), .fault(fault), .busy(busy), .pages_left(pages_left),
    .jobs_pending(jobs_pending)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at "cycle 0": just after an edge, DUT idle, inputs quiet
  task automatic do_reset;
    push = 1'b0; pages = 8'd0; jam = 1'b0; jam_clr = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic test_reset;
    push = 1'b0; pages = 8'd0; jam = 1'b0; jam_clr = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({warm, loadpage, printpage, fault, busy} !== 5'b00000) begin
      fails++; $display("FAIL reset_outs got %b exp 00000", {warm, loadpage, printpage, fault, busy});
    end
    tests++;
    if (push_ready !== 1'b1) begin fails++; $display("FAIL reset_push_ready got %b exp 1", push_ready); end
    tests++;
    if (pages_left !== 8'd0 || jobs_pending !== 3'd0) begin
      fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0", pages_left, jobs_pending);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_single_job;
    logic [4:0] exp_o;
    logic [7:0] exp_pl;
    logic [2:0] exp_jp;
    do_reset();
    push = 1'b1; pages = 8'd3;
    for (int c = 1; c <= 30; c++) begin
      tick();
      push = 1'b0;
      exp_o  = {(c >= 2 && c <= 5), (c == 7 || c == 9 || c == 11),
                (c == 8 || c == 10 || c == 12), 1'b0, (c < 29)};
      exp_pl = (c >= 7 && c <= 8) ? 8'd3 : (c >= 9 && c <= 10) ? 8'd2 :
               (c >= 11 && c <= 12) ? 8'd1 : 8'd0;
      exp_jp = (c <= 6) ? 3'd1 : 3'd0;
      tests++;
      if ({warm, loadpage, printpage, fault, busy} !== exp_o) begin
        fails++; $display("FAIL single_outs c=%0d got %b exp %b", c, {warm, loadpage, printpage, fault, busy}, exp_o);
      end
      tests++;
      if (pages_left !== exp_pl) begin
        fails++; $display("FAIL single_pages_left c=%0d got %0d exp %0d", c, pages_left, exp_pl);
      end
      tests++;
      if (jobs_pending !== exp_jp) begin
        fails++; $display("FAIL single_jobs_pending c=%0d got %0d exp %0d", c, jobs_pending, exp_jp);
      end
    end
  endtask

  task automatic test_two_jobs;
    int nw, nl, np;
    nw = 0; nl = 0; np = 0;
    do_reset();
    push = 1'b1; pages = 8'd2;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) pages = 8'd1;
      if (c == 2) push = 1'b0;
      nw += int'(warm); nl += int'(loadpage); np += int'(printpage);
      if (c == 2 || c == 7 || c == 12) begin
        tests++;
        if (jobs_pending !== ((c == 2) ? 3'd2 : (c == 7) ? 3'd1 : 3'd0)) begin
          fails++; $display("FAIL two_jobs_pending c=%0d got %0d", c, jobs_pending);
        end
      end
      if (c == 11) begin
        tests++;
        if ({warm, loadpage, printpage} !== 3'b000 || pages_left !== 8'd0) begin
          fails++; $display("FAIL two_ready_gap got %b/%0d exp 000/0", {warm, loadpage, printpage}, pages_left);
        end
      end
    end
    tests++;
    if (nw != 4 || nl != 3 || np != 3) begin
      fails++; $display("FAIL two_counts got warm=%0d load=%0d print=%0d exp 4/3/3", nw, nl, np);
    end
  endtask

  task automatic test_overflow;
    int nw, nl, np;
    logic [7:0] pg [5];
    pg[0] = 8'd1; pg[1] = 8'd2; pg[2] = 8'd1; pg[3] = 8'd1; pg[4] = 8'd7;
    nw = 0; nl = 0; np = 0;
    do_reset();
    push = 1'b1; pages = pg[0];
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c <= 4) pages = pg[c];
      if (c == 5) push = 1'b0;
      nw += int'(warm); nl += int'(loadpage); np += int'(printpage);
      if (c == 3 || c == 4 || c == 7) begin
        tests++;
        if (push_ready !== (c != 4)) begin
          fails++; $display("FAIL ovf_push_ready c=%0d got %b exp %b", c, push_ready, (c != 4));
        end
      end
      if (c == 5) begin
        tests++;
        if (jobs_pending !== 3'd4) begin fails++; $display("FAIL ovf_full_count got %0d exp 4", jobs_pending); end
      end
    end
    tests++;
    if (nw != 4 || nl != 5 || np != 5) begin
      fails++; $display("FAIL ovf_counts got warm=%0d load=%0d print=%0d exp 4/5/5", nw, nl, np);
    end
    tests++;
    if (busy !== 1'b0 || jobs_pending !== 3'd0) begin
      fails++; $display("FAIL ovf_sleep got busy=%b jobs=%0d exp 0/0", busy, jobs_pending);
    end
  endtask

  task automatic test_jam;
    int nw, nl, np;
    nw = 0; nl = 0; np = 0;
    do_reset();
    push = 1'b1; pages = 8'd3;
    for (int c = 1; c <= 26; c++) begin
      tick();
      case (c)
        1:  push = 1'b0;
        10: jam = 1'b1;
        12: jam_clr = 1'b1;
        13: begin jam = 1'b0; jam_clr = 1'b0; end
        14: jam_clr = 1'b1;
        15: jam_clr = 1'b0;
        24: jam = 1'b1;
        25: jam = 1'b0;
        default: ;
      endcase
      if (c >= 15) begin nw += int'(warm); nl += int'(loadpage); np += int'(printpage); end
      if (c == 10) begin
        tests++;
        if (printpage !== 1'b1 || pages_left !== 8'd2) begin
          fails++; $display("FAIL jam_pre got print=%b pl=%0d exp 1/2", printpage, pages_left);
        end
      end
      if (c == 11 || c == 13 || c == 14) begin
        tests++;
        if ({fault, printpage, loadpage, warm} !== 4'b1000 || pages_left !== 8'd2) begin
          fails++; $display("FAIL jam_hold c=%0d got %b pl=%0d exp 1000 pl=2", c, {fault, printpage, loadpage, warm}, pages_left);
        end
      end
      if (c == 15) begin
        tests++;
        if (warm !== 1'b1 || fault !== 1'b0) begin
          fails++; $display("FAIL jam_rewarm got warm=%b fault=%b exp 1/0", warm, fault);
        end
      end
      if (c == 24 || c == 25) begin
        tests++;
        if ({warm, loadpage, printpage, fault} !== 4'b0000 || pages_left !== 8'd0) begin
          fails++; $display("FAIL jam_ready c=%0d got %b pl=%0d exp 0000 pl=0", c, {warm, loadpage, printpage, fault}, pages_left);
        end
      end
    end
    tests++;
    if (nw != 4 || nl != 2 || np != 2) begin
      fails++; $display("FAIL jam_resume got warm=%0d load=%0d print=%0d exp 4/2/2", nw, nl, np);
    end
  endtask

  task automatic test_zero_job;
    int nl;
    nl = 0;
    do_reset();
    push = 1'b1; pages = 8'd0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) pages = 8'd1;
      if (c == 2) push = 1'b0;
      nl += int'(loadpage);
      if (c == 7) begin
        tests++;
        if (loadpage !== 1'b0 || jobs_pending !== 3'd1 || pages_left !== 8'd0) begin
          fails++; $display("FAIL zero_discard got load=%b jobs=%0d pl=%0d exp 0/1/0", loadpage, jobs_pending, pages_left);
        end
      end
      if (c == 8) begin
        tests++;
        if (loadpage !== 1'b1 || jobs_pending !== 3'd0 || pages_left !== 8'd1) begin
          fails++; $display("FAIL zero_next got load=%b jobs=%0d pl=%0d exp 1/0/1", loadpage, jobs_pending, pages_left);
        end
      end
      if (c == 9) begin
        tests++;
        if (printpage !== 1'b1) begin fails++; $display("FAIL zero_print got %b exp 1", printpage); end
      end
    end
    tests++;
    if (nl != 1) begin fails++; $display("FAIL zero_loads got %0d exp 1", nl); end
  endtask

  task automatic test_back_to_back;
    int nw;
    nw = 0;
    do_reset();
    push = 1'b1; pages = 8'd1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1)  push = 1'b0;
      if (c == 10) begin push = 1'b1; pages = 8'd2; end
      if (c == 11) push = 1'b0;
      if (c >= 9) nw += int'(warm);
      if (c == 11) begin
        tests++;
        if (loadpage !== 1'b0 || jobs_pending !== 3'd1) begin
          fails++; $display("FAIL b2b_pop got load=%b jobs=%0d exp 0/1", loadpage, jobs_pending);
        end
      end
      if (c == 12) begin
        tests++;
        if (loadpage !== 1'b1 || pages_left !== 8'd2) begin
          fails++; $display("FAIL b2b_load got load=%b pl=%0d exp 1/2", loadpage, pages_left);
        end
      end
    end
    tests++;
    if (nw != 0 || pages_left !== 8'd0) begin
      fails++; $display("FAIL b2b_nowarm got warm=%0d pl=%0d exp 0/0", nw, pages_left);
    end
  endtask

  task automatic test_reset_mid;
    int nact;
    nact = 0;
    do_reset();
    push = 1'b1; pages = 8'd2;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) push = 1'b0;
    end
    tests++;
    if (printpage !== 1'b1 || jobs_pending !== 3'd2) begin
      fails++; $display("FAIL rstmid_pre got print=%b jobs=%0d exp 1/2", printpage, jobs_pending);
    end
    #2 rst_n = 1'b1;
    #1;
    tests++;
    if ({warm, loadpage, printpage, fault, busy} !== 5'b00000 || push_ready !== 1'b1 ||
        jobs_pending !== 3'd0 || pages_left !== 8'd0) begin
      fails++; $display("FAIL rstmid_async got outs=%b ready=%b jobs=%0d pl=%0d exp 00000/1/0/0",
                        {warm, loadpage, printpage, fault, busy}, push_ready, jobs_pending, pages_left);
    end
    tick(); tick();
    rst_n = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      nact += int'(warm | loadpage | printpage | fault | busy);
    end
    tests++;
    if (nact != 0) begin fails++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", nact); end
    push = 1'b1; pages = 8'd1;
    tick(); push = 1'b0;
    tick();
    tests++;
    if (warm !== 1'b1) begin fails++; $display("FAIL rstmid_restart got warm=%b exp 1", warm); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_two_jobs();
    test_overflow();
    test_jam();
    test_zero_job();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
